ram_port_ctrl: RTL and testbench
================================

// Module: ram_port_ctrl
// PURPOSE
//  Front-end controller directly upstream of single_port_ram. Converts a valid/ready
//  request stream (read/write) into the RAM's data/addr/we port and returns read data
//  with a 1-cycle rsp_valid strobe. Also provides a hardware init sweep that writes a
//  fixed value to every location. Range-checks addresses against DEPTH.
// PARAMETERS
//  ADDR_WIDTH  6   address width; must match the RAM's addr_width
//  DATA_WIDTH  8   data width; must match the RAM's data_width
//  DEPTH       64  number of valid locations; 1 <= DEPTH <= 2**ADDR_WIDTH
// PORTS
//  clk         in   1           single clock; all state updates on posedge
//  rst         in   1           asynchronous, active-high reset
//  init_start  in   1           start init sweep (sampled only in IDLE)
//  init_value  in   DATA_WIDTH  fill value; latched in the cycle init_start is accepted
//  init_busy   out  1           high while the sweep is running
//  init_done   out  1           1-cycle pulse when the sweep completes
//  req_valid   in   1           request present
//  req_ready   out  1           controller accepts the request this cycle
//  req_we      in   1           1 = write, 0 = read
//  req_addr    in   ADDR_WIDTH  request address
//  req_wdata   in   DATA_WIDTH  write data
//  rsp_valid   out  1           read response valid (1 cycle; no backpressure)
//  rsp_data    out  DATA_WIDTH  read data; 0 when rsp_err
//  rsp_err     out  1           out-of-range read (req_addr >= DEPTH)
//  ram_data    out  DATA_WIDTH  to RAM data
//  ram_addr    out  ADDR_WIDTH  to RAM addr
//  ram_we      out  1           to RAM we
//  ram_q       in   DATA_WIDTH  from RAM q; equals ram[addr latched on last we=0 edge]
// BEHAVIOUR
//  Reset: state=IDLE; init_busy=0; init_done=0; rsp_valid=0; rsp_err=0; ram_we=0.
//   req_ready=0 while rst is high.
//  FSM: IDLE, INIT.
//   IDLE: req_ready = !init_start. init_start=1 -> INIT, counter=0, init_value latched.
//    init_start has priority over any request in the same cycle; that request is not accepted.
//   INIT: ram_we=1, ram_addr=counter, ram_data=latched value, req_ready=0, init_busy=1.
//    The counter increments once per cycle. After the write to DEPTH-1 -> IDLE.
//    init_done pulses in the first IDLE cycle. The sweep lasts exactly DEPTH cycles.
//    init_start is ignored while in INIT.
//  Request path, IDLE only, combinational into the RAM:
//   ram_addr=req_addr and ram_data=req_wdata.
//   ram_we = req_valid & req_ready & req_we & (req_addr < DEPTH).
//   With no request, ram_we=0. The RAM then loads req_addr into its address register;
//    this is harmless.
//  Write accepted at edge N: RAM is updated at edge N. No response is generated.
//   An out-of-range write is silently dropped.
//  Read accepted at edge N: rsp_valid=1 for the cycle between edges N and N+1.
//   rsp_data=ram_q (combinational) during that cycle.
//   Out of range: rsp_err=1 and rsp_data=0 in that cycle.
//  Reads may issue back-to-back, one per cycle, with one response per cycle.
//  Read-after-write to the same address in the next cycle returns the new data.
//  The controller has no internal read buffering; the consumer must take rsp_data while
//   rsp_valid=1.
//  Reset during INIT: return to IDLE immediately. Locations already written keep the new
//   value. No init_done pulse. A pending rsp_valid is cleared.
// TESTING
//  1. Reset, then init_start with init_value=8'hA5 -> init_busy high for 64 cycles;
//     ram_addr 0..63 with ram_we=1; init_done pulses once; reads of addr 0 and 63 return A5.
//  2. Write 8'h3C to addr 5, then read addr 5 in the next cycle -> rsp_valid 1 cycle later,
//     rsp_data=3C, rsp_err=0.
//  3. Back-to-back reads of addrs 1,2,3 after writing 11,22,33 -> rsp_valid three
//     consecutive cycles with data 11,22,33.
//  4. DEPTH=48: write to addr 50, then read addr 50 -> ram_we stays 0; rsp_err=1 and
//     rsp_data=0.
//  5. init_start and req_valid together -> req_ready=0 and the request is not accepted;
//     the request is accepted in the first IDLE cycle after init_done.
//  6. Assert rst at sweep cycle 20 -> init_busy=0 immediately; no init_done;
//     addr 10 reads the fill value; addr 40 keeps its old content.

Source files
------------

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: valid/ready request front end for single_port_ram.
// It also runs a hardware fill sweep and range-checks addresses against DEPTH.
module ram_port_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    input  logic [DATA_WIDTH-1:0] init_value,
    output logic                  init_busy,
    output logic                  init_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    typedef enum logic {IDLE, INIT} state_t;
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_val;
    logic                  r_done, r_rsp_valid, r_rsp_err;
    logic                  w_in_range, w_last, w_rd;
    assign w_in_range = {1'b0, req_addr} < LP_DEPTH;
    assign w_last     = r_cnt == LP_LAST;
    assign w_rd       = req_valid & req_ready & ~req_we;
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = req_addr;
        ram_data  = req_wdata;
        if (r_state == INIT) begin
            ram_we   = 1'b1;
            ram_addr = r_cnt;
            ram_data = r_val;
            w_next   = w_last ? IDLE : INIT;
        end else begin
            req_ready = ~rst & ~init_start;
            ram_we    = req_valid & req_ready & req_we & w_in_range;
            w_next    = init_start ? INIT : IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_val       <= '0;
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= r_state == INIT ? r_cnt + 1'b1 : '0;
            r_val       <= (r_state == IDLE && init_start) ? init_value : r_val;
            r_done      <= r_state == INIT && w_last;
            r_rsp_valid <= w_rd;
            r_rsp_err   <= w_rd & ~w_in_range;
        end
    end
    assign init_busy = r_state == INIT;
    assign init_done = r_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    // Out-of-range reads still drive the RAM address, so the returned word must be masked.
    assign rsp_data  = r_rsp_err ? '0 : ram_q;
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: directed and random checks of ram_port_ctrl (DEPTH=48) against a memory-image model.
module tb_ram_port_ctrl;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int D  = 48;
    logic          clk = 1'b0;
    logic          rst, init_start, req_valid, req_we;
    logic [DW-1:0] init_value, req_wdata;
    logic [AW-1:0] req_addr;
    logic          init_busy, init_done, req_ready, rsp_valid, rsp_err, ram_we;
    logic [DW-1:0] rsp_data, ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram [0:63];
    logic [AW-1:0] ram_a = '0;
    logic [DW-1:0] exp_mem [0:63];
    int            errs = 0;
    int            checks = 0;
    bit            pend_v = 0;
    bit            pend_e = 0;
    logic [DW-1:0] pend_d = '0;

    ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .init_value(init_value),
        .init_busy(init_busy), .init_done(init_done), .req_valid(req_valid),
        .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .ram_data(ram_data), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural single_port_ram: address register loads only on read edges.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_data;
        else        ram_a <= ram_addr;
    end
    assign ram_q = ram[ram_a];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        @(posedge clk);
        #1;
        init_start = 1'b0;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        ok = a < D;
        chk("rsp_valid", rsp_valid, pend_v);
        if (pend_v) begin
            chk("rsp_err", rsp_err, pend_e);
            chk("rsp_data", rsp_data, pend_d);
        end
        chk("req_ready", req_ready, 1);
        chk("ram_we", ram_we, v && we && ok);
        if (v) chk("ram_addr", ram_addr, a);
        chk("busy_idle", init_busy, 0);
        chk("done_idle", init_done, 0);
        pend_v = v && !we;
        pend_e = !ok;
        pend_d = ok ? exp_mem[a] : '0;
        if (v && we && ok) exp_mem[a] = d;
    endtask

    task automatic sweep(input logic [DW-1:0] val, input int abort_at, input bit v, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        init_start = 1'b1; init_value = val;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        chk("start_ready", req_ready, 0);
        chk("start_we", ram_we, 0);
        chk("start_busy", init_busy, 0);
        @(posedge clk);
        #1;
        init_start = 1'b0; init_value = ~val;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("sw_busy", init_busy, 1);
            chk("sw_we", ram_we, 1);
            chk("sw_addr", ram_addr, i);
            chk("sw_data", ram_data, val);
            chk("sw_ready", req_ready, 0);
            chk("sw_done", init_done, 0);
            chk("sw_rsp", rsp_valid, 0);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk("ab_busy", init_busy, 0);
                chk("ab_we", ram_we, 0);
                chk("ab_ready", req_ready, 0);
                @(negedge clk);
                chk("ab_done", init_done, 0);
                rst = 1'b0;
                pend_v = 0;
                return;
            end
            exp_mem[i] = val;
            init_start = (i == 10);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("end_done", init_done, 1);
        chk("end_busy", init_busy, 0);
        chk("end_ready", req_ready, 1);
        chk("end_we", ram_we, v && we && a < D);
        if (v && we && a < D) exp_mem[a] = d;
        pend_v = v && !we;
        pend_e = !(a < D);
        pend_d = a < D ? exp_mem[a] : '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin ram[i] = '0; exp_mem[i] = '0; end
        rst = 1'b1; init_start = 1'b0; init_value = '0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = '0; req_wdata = '0;
        #3;
        chk("rst_busy", init_busy, 0);
        chk("rst_done", init_done, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        // Fill sweep with a competing write held across it
        sweep(8'hA5, -1, 1, 1, 6'd7, 8'h77);
        cycle(1, 0, 6'd0, 8'h00);
        cycle(1, 0, 6'(D - 1), 8'h00);
        cycle(1, 0, 6'd7, 8'h00);
        cycle(0, 0, 6'd0, 8'h00);
        // Read-after-write and back-to-back reads
        cycle(1, 1, 6'd5, 8'h3C);
        cycle(1, 0, 6'd5, 8'h00);
        cycle(1, 1, 6'd1, 8'h11);
        cycle(1, 1, 6'd2, 8'h22);
        cycle(1, 1, 6'd3, 8'h33);
        cycle(1, 0, 6'd1, 8'h00);
        cycle(1, 0, 6'd2, 8'h00);
        cycle(1, 0, 6'd3, 8'h00);
        // Range boundary around DEPTH
        cycle(1, 1, 6'd50, 8'hAB);
        cycle(1, 0, 6'd50, 8'h00);
        cycle(1, 1, 6'd47, 8'h47);
        cycle(1, 1, 6'd48, 8'h48);
        cycle(1, 0, 6'd47, 8'h00);
        cycle(1, 0, 6'd48, 8'h00);
        cycle(1, 0, 6'd63, 8'h00);
        cycle(0, 0, 6'd0, 8'h00);
        repeat (300) cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                           6'($urandom_range(0, 63)), 8'($urandom));
        cycle(0, 0, 6'd0, 8'h00);
        // Reset in the middle of a sweep
        cycle(1, 1, 6'd40, 8'hC4);
        cycle(1, 1, 6'd10, 8'h01);
        cycle(0, 0, 6'd0, 8'h00);
        sweep(8'h5A, 20, 0, 0, 6'd0, 8'h00);
        cycle(1, 0, 6'd10, 8'h00);
        cycle(1, 0, 6'd40, 8'h00);
        cycle(1, 0, 6'd19, 8'h00);
        cycle(1, 0, 6'd20, 8'h00);
        cycle(0, 0, 6'd0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
